// File: rtl/dmem_banked_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_banked_ctrl_if
//   Request/response bundle between the MEM stage (master) and the data-memory
//   controller (slave).
//
//   Handshake: a request transfers on a rising clock edge where req_valid and
//   req_ready are both 1. The master keeps req_valid and the request fields
//   stable until that edge. req_valid seen while req_ready=0 has no effect.
//   The response is a single-cycle resp_valid pulse. resp_rdata/resp_err are
//   meaningful in that cycle and hold their value until the next response.
//
// Signals:
//   req_valid   master->slave  request present
//   req_ready   slave->master  controller can accept a request this cycle
//   req_we      master->slave  1 = store, 0 = load
//   req_addr    master->slave  byte address [ADDR_W-1:0]
//   req_wdata   master->slave  store data, right-aligned
//   req_funct3  master->slave  instruction bits 14:12
//   resp_valid  slave->master  one-cycle completion pulse
//   resp_rdata  slave->master  extended load result (0 for stores/errors)
//   resp_err    slave->master  access faulted, qualified by resp_valid
// -----------------------------------------------------------------------------
interface dmem_banked_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_banked_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_banked_ctrl
//   Data-memory controller for the RV32I pipeline. Owns a byte-lane RAM of
//   DEPTH 32-bit words and executes LB/LH/LW/LBU/LHU and SB/SH/SW through a
//   valid/ready request and a one-cycle response pulse, with WAIT_CYCLES
//   programmable wait states per access.
//
// Parameters:
//   ADDR_W       byte-address width (DEPTH*4 must not exceed 2**ADDR_W)
//   DEPTH        number of 32-bit words
//   WAIT_CYCLES  extra wait states per access, 0..15
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   bus          dmem_banked_ctrl_if.slave request/response bundle
//   o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Configuration macro:
//   DMEM_MISALIGN_TRAP_EN  defined: misaligned accesses fault (resp_err=1,
//                          no write, rdata 0). Undefined: the low address
//                          bits are forced to natural alignment, no fault.
//
// Faults (resp_err=1, write suppressed, rdata=0): word index >= DEPTH,
// funct3 in {011,110,111}, or a store with funct3[2] set.
// -----------------------------------------------------------------------------
module dmem_banked_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  dmem_banked_ctrl_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;

  // Latched request, used when the access happens after wait states.
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_f3;

  logic [31:0]       r_rdata;
  logic              r_err;

  logic [31:0]       r_mem [DEPTH];

  logic              w_ready;
  logic              w_accept;
  logic              w_resp_valid;
  logic              w_do_access;

  logic              w_op_we;
  logic [ADDR_W-1:0] w_op_addr;
  logic [31:0]       w_op_wdata;
  logic [2:0]        w_op_f3;

  logic [ADDR_W-3:0] w_idx;
  logic [IDX_W-1:0]  w_ram_idx;
  logic              w_oor;
  logic              w_f3_bad;
  logic              w_st_bad;
  logic              w_mis;
  logic              w_err;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready      = 1'b0;
    w_resp_valid = 1'b0;
    w_do_access  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Ready drops combinationally while reset is held.
        w_ready     = ~reset;
        w_do_access = (WAIT_CYCLES == 0) && bus.req_valid && ~reset;
      end
      ST_WAIT: begin
        w_do_access = (r_cnt == 4'd1);
      end
      ST_RESP: begin
        w_resp_valid = 1'b1;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  assign w_accept = bus.req_valid && w_ready;

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign o_dbg_state    = r_state;

  // ---------------------------------------------------------------------------
  // Operand select: with no wait states the access happens on the accepting
  // edge, so the live bus fields are used; otherwise the latched copy.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_op_we    = bus.req_we;
      w_op_addr  = bus.req_addr;
      w_op_wdata = bus.req_wdata;
      w_op_f3    = bus.req_funct3;
    end else begin
      w_op_we    = r_we;
      w_op_addr  = r_addr;
      w_op_wdata = r_wdata;
      w_op_f3    = r_f3;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode: range, legality, alignment
  // ---------------------------------------------------------------------------
  assign w_idx     = w_op_addr[ADDR_W-1:2];
  assign w_oor     = ({1'b0, w_idx} >= (ADDR_W-1)'(DEPTH));
  // Out-of-range indices are redirected to word 0; the access is faulted anyway.
  assign w_ram_idx = w_oor ? '0 : w_idx[IDX_W-1:0];
  assign w_f3_bad  = (w_op_f3 == 3'b011) || (w_op_f3 == 3'b110) || (w_op_f3 == 3'b111);
  assign w_st_bad  = w_op_we && w_op_f3[2];
  assign w_mis     = ((w_op_f3[1:0] == 2'b01) && w_op_addr[0]) ||
                     ((w_op_f3[1:0] == 2'b10) && (w_op_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_err = w_oor || w_f3_bad || w_st_bad || w_mis;
  assign w_off = w_op_addr[1:0];
`else
  assign w_err = w_oor || w_f3_bad || w_st_bad;
  always_comb begin
    case (w_op_f3[1:0])
      2'b00:   w_off = w_op_addr[1:0];
      2'b01:   w_off = {w_op_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Store lane enables and replicated data (lane o gets bits 8o+7:8o)
  // ---------------------------------------------------------------------------
  always_comb begin
    case (w_op_f3[1:0])
      2'b00: begin
        w_be = 4'b0001 << w_off;
        w_wd = {4{w_op_wdata[7:0]}};
      end
      2'b01: begin
        w_be = 4'b0011 << w_off;
        w_wd = {2{w_op_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = w_op_wdata;
      end
    endcase
  end

  // RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (w_do_access && w_op_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_ram_idx][8*i +: 8] <= w_wd[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  assign w_word = r_mem[w_ram_idx];

  always_comb begin
    case (w_off)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_op_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: request latch, wait counter, response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_f3    <= 3'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_f3    <= bus.req_funct3;
        r_cnt   <= WAIT_L;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_access) begin
        r_rdata <= (w_err || w_op_we) ? 32'd0 : w_load;
        r_err   <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_banked_ctrl
//   Two controllers (0 and 3 wait states, ADDR_W=10, DEPTH=128) driven in turn.
//   A byte-array model computes every response from the load/store rules;
//   one monitor checks ready/valid/rdata/err on every falling edge, and
//   directed steps pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_dmem_banked_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 128;
  localparam int NB    = DEPTH * 4;

  logic clk;
  logic reset;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  dmem_banked_ctrl_if #(.ADDR_W(AW)) if0 ();
  dmem_banked_ctrl_if #(.ADDR_W(AW)) if1 ();
  logic [1:0] dbg0, dbg1;

  dmem_banked_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .o_dbg_state(dbg0));
  dmem_banked_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .o_dbg_state(dbg1));

  // Driver side
  logic [1:0]    drv_valid = '0;
  logic [1:0]    drv_we    = '0;
  logic [AW-1:0] drv_addr [2];
  logic [31:0]   drv_wdata[2];
  logic [2:0]    drv_f3   [2];

  assign if0.req_valid  = drv_valid[0];
  assign if0.req_we     = drv_we[0];
  assign if0.req_addr   = drv_addr[0];
  assign if0.req_wdata  = drv_wdata[0];
  assign if0.req_funct3 = drv_f3[0];
  assign if1.req_valid  = drv_valid[1];
  assign if1.req_we     = drv_we[1];
  assign if1.req_addr   = drv_addr[1];
  assign if1.req_wdata  = drv_wdata[1];
  assign if1.req_funct3 = drv_f3[1];

  // Observed side
  logic [1:0]  mon_ready, mon_rv, mon_err;
  logic [31:0] mon_rd[2];
  assign mon_ready[0] = if0.req_ready;
  assign mon_ready[1] = if1.req_ready;
  assign mon_rv[0]    = if0.resp_valid;
  assign mon_rv[1]    = if1.resp_valid;
  assign mon_err[0]   = if0.resp_err;
  assign mon_err[1]   = if1.resp_err;
  assign mon_rd[0]    = if0.resp_rdata;
  assign mon_rd[1]    = if1.resp_rdata;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: byte-addressed memory per controller
  // ---------------------------------------------------------------------------
  logic [7:0] mem_m [2][NB];

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic model_access(input int d, input bit we, input logic [AW-1:0] addr,
                              input logic [31:0] wd, input logic [2:0] f3,
                              output logic [31:0] rd, output bit er);
    int a;
    int size;
    logic [31:0] v;
    rd = 32'd0;
    er = 1'b0;
    a = int'(addr);
    size = 1 << f3[1:0];
    if ((a / 4) >= DEPTH || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2])) begin
      er = 1'b1;
      return;
    end
    if ((a % size) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      er = 1'b1;
      return;
`else
      a = a - (a % size);
`endif
    end
    if (we) begin
      for (int i = 0; i < size; i++) mem_m[d][a+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | ({24'd0, mem_m[d][a+i]} << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (~32'd0 << (8*size));
      rd = v;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard: one pending access per controller, expected to
  // complete WAIT edges after its accepting edge.
  // ---------------------------------------------------------------------------
  bit          pend    [2] = '{0, 0};
  int          acc_edge[2] = '{0, 0};
  bit          t_we    [2];
  logic [AW-1:0] t_addr[2];
  logic [31:0] t_wd    [2];
  logic [2:0]  t_f3    [2];
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};
  bit          last_err[2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        chk($sformatf("d%0d reset ready", d), {31'd0, mon_ready[d]}, 32'd0);
        chk($sformatf("d%0d reset resp_valid", d), {31'd0, mon_rv[d]}, 32'd0);
        chk($sformatf("d%0d reset rdata", d), mon_rd[d], 32'd0);
        chk($sformatf("d%0d reset err", d), {31'd0, mon_err[d]}, 32'd0);
        pend[d]     = 1'b0;
        last_rd[d]  = 32'd0;
        last_err[d] = 1'b0;
      end else begin
        bit exp_ready;
        logic [31:0] erd;
        bit eerr;
        exp_ready = !pend[d];
        chk($sformatf("d%0d ready", d), {31'd0, mon_ready[d]}, {31'd0, exp_ready});
        if (pend[d] && cyc == acc_edge[d]) begin
          model_access(d, t_we[d], t_addr[d], t_wd[d], t_f3[d], erd, eerr);
          chk($sformatf("d%0d resp_valid", d), {31'd0, mon_rv[d]}, 32'd1);
          chk($sformatf("d%0d rdata @%h f3=%0d we=%0d", d, t_addr[d], t_f3[d], t_we[d]), mon_rd[d], erd);
          chk($sformatf("d%0d err @%h f3=%0d we=%0d", d, t_addr[d], t_f3[d], t_we[d]),
              {31'd0, mon_err[d]}, {31'd0, eerr});
          last_rd[d]  = erd;
          last_err[d] = eerr;
          pend[d]     = 1'b0;
        end else begin
          chk($sformatf("d%0d idle resp_valid", d), {31'd0, mon_rv[d]}, 32'd0);
          chk($sformatf("d%0d held rdata", d), mon_rd[d], last_rd[d]);
          chk($sformatf("d%0d held err", d), {31'd0, mon_err[d]}, {31'd0, last_err[d]});
        end
        if (exp_ready && drv_valid[d]) begin
          pend[d]     = 1'b1;
          acc_edge[d] = cyc + 1 + wait_of(d);
          t_we[d]     = drv_we[d];
          t_addr[d]   = drv_addr[d];
          t_wd[d]     = drv_wdata[d];
          t_f3[d]     = drv_f3[d];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver task: called at posedge+1; returns at posedge+1.
  // lat   = falling edges from the accepting edge to the response sample
  // nbusy = those samples with req_ready low
  // ---------------------------------------------------------------------------
  task automatic do_req(input int d, input bit we, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nbusy, output int acc_c);
    bit ok;
    rd = 32'd0; er = 1'b0; lat = 0; nbusy = 0; acc_c = -1;
    drv_we[d] = we; drv_addr[d] = addr; drv_wdata[d] = wd; drv_f3[d] = f3;
    drv_valid[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mon_ready[d]) begin
        ok = 1'b1;
        acc_c = cyc + 1;
      end
    end
    if (!ok) begin
      fail_now($sformatf("d%0d accept", d));
      @(posedge clk); #1;
      drv_valid[d] = 1'b0;
      return;
    end
    // req_valid stays high while busy; it must be ignored.
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (!mon_ready[d]) nbusy++;
      if (mon_rv[d]) begin
        ok = 1'b1;
        rd = mon_rd[d];
        er = mon_err[d];
      end
    end
    if (!ok) fail_now($sformatf("d%0d response", d));
    @(posedge clk); #1;
    drv_valid[d] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] rd;
  logic        er;
  int          lat, nbusy, acc_a, acc_b;
  logic [2:0]  f3_tab[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    for (int d = 0; d < 2; d++) begin
      drv_addr[d] = '0; drv_wdata[d] = '0; drv_f3[d] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-reset ready d0", {31'd0, mon_ready[0]}, 32'd1);
    chk("post-reset ready d1", {31'd0, mon_ready[1]}, 32'd1);
    chk("post-reset rdata d1", mon_rd[1], 32'd0);
    @(posedge clk); #1;

    // Preload every word so all later loads have known data.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        do_req(d, 1'b1, AW'(w * 4), $urandom, 3'b010, rd, er, lat, nbusy, acc_a);

    // ---- zero wait states: literal expectations ----
    do_req(0, 1'b1, 10'h010, 32'hDEADBEEF, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d0 SW latency", lat, 1);
    chk("d0 SW err", {31'd0, er}, 32'd0);
    do_req(0, 1'b0, 10'h010, 32'd0, 3'b010, rd, er, lat, nbusy, acc_b);
    chk("d0 LW 0x10", rd, 32'hDEADBEEF);
    chk("d0 LW latency", lat, 1);
    chk("d0 accept spacing", acc_b - acc_a, 2);
    do_req(0, 1'b1, 10'h012, 32'h0000005A, 3'b000, rd, er, lat, nbusy, acc_a);
    do_req(0, 1'b0, 10'h010, 32'd0, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d0 LW after SB", rd, 32'hDE5ABEEF);
    do_req(0, 1'b0, 10'h013, 32'd0, 3'b000, rd, er, lat, nbusy, acc_a);
    chk("d0 LB 0x13", rd, 32'hFFFFFFDE);
    do_req(0, 1'b0, 10'h013, 32'd0, 3'b100, rd, er, lat, nbusy, acc_a);
    chk("d0 LBU 0x13", rd, 32'h000000DE);
    do_req(0, 1'b0, 10'h010, 32'd0, 3'b001, rd, er, lat, nbusy, acc_a);
    chk("d0 LH 0x10", rd, 32'hFFFFBEEF);
    do_req(0, 1'b0, 10'h012, 32'd0, 3'b101, rd, er, lat, nbusy, acc_a);
    chk("d0 LHU 0x12", rd, 32'h0000DE5A);

    // Misaligned stores
    do_req(0, 1'b1, 10'h011, 32'h11223344, 3'b010, rd, er, lat, nbusy, acc_a);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("d0 SW@0x11 err", {31'd0, er}, 32'd1);
    do_req(0, 1'b1, 10'h013, 32'h00007788, 3'b001, rd, er, lat, nbusy, acc_a);
    chk("d0 SH@0x13 err", {31'd0, er}, 32'd1);
    do_req(0, 1'b0, 10'h010, 32'd0, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d0 memory unchanged", rd, 32'hDE5ABEEF);
`else
    chk("d0 SW@0x11 err", {31'd0, er}, 32'd0);
    do_req(0, 1'b0, 10'h010, 32'd0, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d0 LW after SW@0x11", rd, 32'h11223344);
    do_req(0, 1'b1, 10'h013, 32'h00007788, 3'b001, rd, er, lat, nbusy, acc_a);
    do_req(0, 1'b0, 10'h015, 32'd0, 3'b010, rd, er, lat, nbusy, acc_a);
    do_req(0, 1'b0, 10'h010, 32'd0, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d0 LW after SH@0x13", rd, 32'h77883344);
`endif

    // Faults
    do_req(0, 1'b0, 10'h200, 32'd0, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d0 LW@0x200 err", {31'd0, er}, 32'd1);
    chk("d0 LW@0x200 rdata", rd, 32'd0);
    do_req(0, 1'b0, 10'h010, 32'd0, 3'b011, rd, er, lat, nbusy, acc_a);
    chk("d0 funct3=011 err", {31'd0, er}, 32'd1);
    do_req(0, 1'b1, 10'h020, 32'hFFFFFFFF, 3'b100, rd, er, lat, nbusy, acc_a);
    chk("d0 store funct3=100 err", {31'd0, er}, 32'd1);

    // ---- three wait states: timing literals ----
    do_req(1, 1'b1, 10'h040, 32'h13579BDF, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d1 SW latency", lat, 4);
    chk("d1 ready-low cycles", nbusy, 4);
    do_req(1, 1'b0, 10'h040, 32'd0, 3'b010, rd, er, lat, nbusy, acc_b);
    chk("d1 accept spacing", acc_b - acc_a, 5);
    chk("d1 LW 0x40", rd, 32'h13579BDF);

    // Reset while a store waits: it must never land.
    drv_we[1] = 1'b1; drv_addr[1] = 10'h040; drv_wdata[1] = 32'hCAFEF00D; drv_f3[1] = 3'b010;
    drv_valid[1] = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (mon_ready[1]) ok = 1'b1;
      end
      if (!ok) fail_now("d1 abort accept");
    end
    @(posedge clk); #1;
    drv_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("d1 ready during reset", {31'd0, mon_ready[1]}, 32'd0);
    idle_cycles(2);
    reset = 1'b0;
    @(negedge clk);
    chk("d1 ready after reset", {31'd0, mon_ready[1]}, 32'd1);
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (mon_rv[1]) seen++;
      end
      chk("d1 no resp after abort", seen, 0);
    end
    @(posedge clk); #1;
    do_req(1, 1'b0, 10'h040, 32'd0, 3'b010, rd, er, lat, nbusy, acc_a);
    chk("d1 LW keeps old data", rd, 32'h13579BDF);

    // ---- randomized traffic ----
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 250; k++) begin
        bit we;
        logic [2:0] f3;
        logic [AW-1:0] addr;
        we = 1'($urandom_range(0, 1));
        f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : f3_tab[$urandom_range(0, 4)];
        addr = ($urandom_range(0, 99) < 85) ? AW'($urandom_range(0, NB - 1))
                                            : AW'($urandom_range(NB, (1 << AW) - 1));
        do_req(d, we, addr, $urandom, f3, rd, er, lat, nbusy, acc_a);
        idle_cycles($urandom_range(0, 2));
      end
    end

    idle_cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
